pipeline_mem_arbiter: RTL and testbench

Parametrised N-channel arbiter that shares one single-ported memory interface among the pipeline's memory clients (instruction fetch, MEM-stage load/store, and later clients such as an indirect-access sequencer). It replaces the fixed two-port split with one arbitrated port, selectable fixed-priority or round-robin, and latches each granted command so a client can drop its request without corrupting the memory transaction. It sits between the pipeline datapath memory ports and the cache/physical memory.

---
 rtl/pipeline_mem_arbiter_if.sv | 39 +++
 rtl/pipeline_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_pipeline_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_mem_arbiter_if.sv
// Client-side and memory-side signals of the shared memory port. The arbiter takes
// the slave view. The master view is the environment: it drives the client requests
// and the memory response.
interface pipeline_mem_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  localparam int BE_W = DATA_W / 8;

  logic [NUM_CH-1:0]        ch_read;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH*BE_W-1:0]   ch_byte_enable;
  logic [NUM_CH-1:0]        ch_resp;
  logic [DATA_W-1:0]        ch_rdata;
  logic                     mem_read;
  logic                     mem_write;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [BE_W-1:0]          mem_byte_enable;
  logic                     mem_resp;
  logic [DATA_W-1:0]        mem_rdata;
  logic [NUM_CH-1:0]        grant;
  logic                     busy;

  modport master (
    output ch_read, ch_write, ch_addr, ch_wdata, ch_byte_enable, mem_resp, mem_rdata,
    input  ch_resp, ch_rdata, mem_read, mem_write, mem_addr, mem_wdata, mem_byte_enable,
    input  grant, busy
  );

  modport slave (
    input  ch_read, ch_write, ch_addr, ch_wdata, ch_byte_enable, mem_resp, mem_rdata,
    output ch_resp, ch_rdata, mem_read, mem_write, mem_addr, mem_wdata, mem_byte_enable,
    output grant, busy
  );
endinterface

// File: rtl/pipeline_mem_arbiter.sv
// N-channel arbiter in front of a single-ported memory. The granted command is latched,
// so that a client which drops or changes its request cannot disturb the memory access.
module pipeline_mem_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int RR_MODE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_mem_arbiter_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W:0] CH_LIMIT = (IDX_W+1)'(NUM_CH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_reg, state_next;

  logic [NUM_CH-1:0] req;
  logic [ADDR_W-1:0] addr_arr  [NUM_CH];
  logic [DATA_W-1:0] wdata_arr [NUM_CH];
  logic [BE_W-1:0]   be_arr    [NUM_CH];

  logic [IDX_W-1:0]  rr_ptr_reg, owner_reg, base_ptr, win_idx;
  logic [IDX_W:0]    cand;
  logic              win_found;
  logic [NUM_CH-1:0] win_onehot, grant_reg, resp_vec;

  logic              rd_reg, wr_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [BE_W-1:0]   be_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign req[gi]       = bus.ch_read[gi] | bus.ch_write[gi];
      assign addr_arr[gi]  = bus.ch_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = bus.ch_wdata[gi*DATA_W +: DATA_W];
      assign be_arr[gi]    = bus.ch_byte_enable[gi*BE_W +: BE_W];
    end
  endgenerate

  // Fixed priority is a round-robin search that always starts at channel 0.
  assign base_ptr   = (RR_MODE != 0) ? rr_ptr_reg : '0;
  assign win_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << win_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, base_ptr} + (IDX_W+1)'(i);
      if (cand >= CH_LIMIT) begin
        cand = cand - CH_LIMIT;
      end
      if (!win_found && req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    resp_vec   = '0;
    case (state_reg)
      IDLE: if (win_found) state_next = BUSY;
      BUSY: begin
        if (bus.mem_resp) begin
          state_next = IDLE;
          resp_vec   = grant_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      owner_reg  <= '0;
      grant_reg  <= '0;
      rd_reg     <= 1'b0;
      wr_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      be_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && win_found) begin
        owner_reg <= win_idx;
        grant_reg <= win_onehot;
        addr_reg  <= addr_arr[win_idx];
        wdata_reg <= wdata_arr[win_idx];
        be_reg    <= be_arr[win_idx];
        // A simultaneous read and write is taken as a write.
        wr_reg    <= bus.ch_write[win_idx];
        rd_reg    <= bus.ch_read[win_idx] & ~bus.ch_write[win_idx];
      end else if (state_reg == BUSY && bus.mem_resp) begin
        grant_reg <= '0;
        rd_reg    <= 1'b0;
        wr_reg    <= 1'b0;
        if (RR_MODE != 0) begin
          rr_ptr_reg <= (owner_reg == IDX_W'(NUM_CH-1)) ? '0 : owner_reg + 1'b1;
        end
      end
    end
  end

  // The strobes are cleared on completion, so they stay low whenever the arbiter is idle.
  assign bus.mem_read        = rd_reg;
  assign bus.mem_write       = wr_reg;
  assign bus.mem_addr        = addr_reg;
  assign bus.mem_wdata       = wdata_reg;
  assign bus.mem_byte_enable = be_reg;
  assign bus.ch_resp         = resp_vec;
  assign bus.ch_rdata        = bus.mem_rdata;
  assign bus.grant           = grant_reg;
  assign bus.busy            = (state_reg == BUSY);
endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Scoreboard bench: dut_a is 2-channel fixed priority, dut_b is 3-channel round-robin.
// Directed stimulus queues the expected transactions, and per-DUT monitors check them.
module tb_pipeline_mem_arbiter;
  typedef struct packed {
    logic [7:0]  grant;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;
  bit   mon_on   = 1'b0;

  exp_t q_a[$];
  exp_t q_b[$];
  int   lat_a = 1, lat_b = 1;
  bit   resp_en_a = 1'b1;
  logic manual_a = 1'b0;
  int   cnt_a = 0, cnt_b = 0;

  pipeline_mem_arbiter_if #(.NUM_CH(2), .ADDR_W(16), .DATA_W(16)) bus_a();
  pipeline_mem_arbiter_if #(.NUM_CH(3), .ADDR_W(16), .DATA_W(16)) bus_b();

  pipeline_mem_arbiter #(.NUM_CH(2), .ADDR_W(16), .DATA_W(16), .RR_MODE(0)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  pipeline_mem_arbiter #(.NUM_CH(3), .ADDR_W(16), .DATA_W(16), .RR_MODE(1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int k, input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [1:0] be);
    bus_a.ch_read[k]               = rd;
    bus_a.ch_write[k]              = wr;
    bus_a.ch_addr[k*16 +: 16]      = addr;
    bus_a.ch_wdata[k*16 +: 16]     = wdata;
    bus_a.ch_byte_enable[k*2 +: 2] = be;
  endtask

  task automatic set_b(input int k, input logic rd, input logic [15:0] addr);
    bus_b.ch_read[k]               = rd;
    bus_b.ch_write[k]              = 1'b0;
    bus_b.ch_addr[k*16 +: 16]      = addr;
    bus_b.ch_wdata[k*16 +: 16]     = 16'h0;
    bus_b.ch_byte_enable[k*2 +: 2] = 2'b11;
  endtask

  task automatic wait_resp_a(input int k);
    int n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus_a.ch_resp[k]) break;
    end
    if (!bus_a.ch_resp[k]) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_resp_a: ch%0d got no ch_resp within 40 cycles, required a pulse", k);
    end
  endtask

  task automatic wait_any_b();
    int n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (|bus_b.ch_resp) break;
    end
    if (bus_b.ch_resp == 3'b000) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_any_b: got no ch_resp within 40 cycles, required a pulse");
    end
  endtask

  // Memory models. They respond lat cycles after the strobe and return the
  // rdata of the transaction that is expected next.
  initial begin
    bus_a.mem_resp  = 1'b0;
    bus_a.mem_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #2;
      if (bus_a.busy === 1'b1) cnt_a++; else cnt_a = 0;
      bus_a.mem_resp  = resp_en_a ? (bus_a.busy === 1'b1 && cnt_a == lat_a + 1) : manual_a;
      bus_a.mem_rdata = (q_a.size() > 0) ? q_a[0].rdata : 16'h0;
    end
  end

  initial begin
    bus_b.mem_resp  = 1'b0;
    bus_b.mem_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #2;
      if (bus_b.busy === 1'b1) cnt_b++; else cnt_b = 0;
      bus_b.mem_resp  = (bus_b.busy === 1'b1 && cnt_b == lat_b + 1);
      bus_b.mem_rdata = (q_b.size() > 0) ? q_b[0].rdata : 16'h0;
    end
  end

  // Monitor for dut_a.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (bus_a.busy) begin
          if (q_a.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL a_unexpected_txn: busy with grant=%b, required idle", bus_a.grant);
          end else begin
            e = q_a[0];
            chk("a_grant", 32'(bus_a.grant), 32'(e.grant));
            chk("a_mem_read", 32'(bus_a.mem_read), 32'(e.rd));
            chk("a_mem_write", 32'(bus_a.mem_write), 32'(e.wr));
            chk("a_mem_addr", 32'(bus_a.mem_addr), 32'(e.addr));
            chk("a_mem_wdata", 32'(bus_a.mem_wdata), 32'(e.wdata));
            chk("a_mem_be", 32'(bus_a.mem_byte_enable), 32'(e.be));
            if (bus_a.mem_resp) begin
              chk("a_ch_resp", 32'(bus_a.ch_resp), 32'(e.grant));
              chk("a_ch_rdata", 32'(bus_a.ch_rdata), 32'(e.rdata));
              $display("dut_a txn grant=%b rd=%0d wr=%0d addr=%h wdata=%h be=%b rdata=%h",
                       bus_a.grant, bus_a.mem_read, bus_a.mem_write, bus_a.mem_addr,
                       bus_a.mem_wdata, bus_a.mem_byte_enable, bus_a.ch_rdata);
              void'(q_a.pop_front());
            end else begin
              chk("a_ch_resp_quiet", 32'(bus_a.ch_resp), 32'h0);
            end
          end
        end else begin
          chk("a_idle_grant", 32'(bus_a.grant), 32'h0);
          chk("a_idle_strobes", 32'({bus_a.mem_read, bus_a.mem_write}), 32'h0);
          chk("a_idle_ch_resp", 32'(bus_a.ch_resp), 32'h0);
        end
      end
    end
  end

  // Monitor for dut_b.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (bus_b.busy) begin
          if (q_b.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL b_unexpected_txn: busy with grant=%b, required idle", bus_b.grant);
          end else begin
            e = q_b[0];
            chk("b_grant", 32'(bus_b.grant), 32'(e.grant));
            chk("b_mem_read", 32'(bus_b.mem_read), 32'(e.rd));
            chk("b_mem_addr", 32'(bus_b.mem_addr), 32'(e.addr));
            if (bus_b.mem_resp) begin
              chk("b_ch_resp", 32'(bus_b.ch_resp), 32'(e.grant));
              chk("b_ch_rdata", 32'(bus_b.ch_rdata), 32'(e.rdata));
              $display("dut_b txn grant=%b addr=%h rdata=%h",
                       bus_b.grant, bus_b.mem_addr, bus_b.ch_rdata);
              void'(q_b.pop_front());
            end else begin
              chk("b_ch_resp_quiet", 32'(bus_b.ch_resp), 32'h0);
            end
          end
        end else begin
          chk("b_idle_grant", 32'(bus_b.grant), 32'h0);
          chk("b_idle_ch_resp", 32'(bus_b.ch_resp), 32'h0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus_a.ch_read = '0; bus_a.ch_write = '0; bus_a.ch_addr = '0;
    bus_a.ch_wdata = '0; bus_a.ch_byte_enable = '0;
    bus_b.ch_read = '0; bus_b.ch_write = '0; bus_b.ch_addr = '0;
    bus_b.ch_wdata = '0; bus_b.ch_byte_enable = '0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_a_grant", 32'(bus_a.grant), 32'h0);
    chk("reset_a_busy", 32'(bus_a.busy), 32'h0);
    chk("reset_a_addr", 32'(bus_a.mem_addr), 32'h0);
    chk("reset_a_wdata", 32'(bus_a.mem_wdata), 32'h0);
    chk("reset_b_busy", 32'(bus_b.busy), 32'h0);
    mon_on = 1'b1;

    // Fixed priority: ch0 read and ch1 write collide, and ch0 goes first.
    q_a.push_back('{grant: 8'b01, rd: 1'b1, wr: 1'b0, addr: 16'h1000, wdata: 16'h0000,
                    be: 2'b11, rdata: 16'h1234});
    q_a.push_back('{grant: 8'b10, rd: 1'b0, wr: 1'b1, addr: 16'h2000, wdata: 16'hBEEF,
                    be: 2'b11, rdata: 16'h0000});
    step();
    set_a(0, 1'b1, 1'b0, 16'h1000, 16'h0000, 2'b11);
    set_a(1, 1'b0, 1'b1, 16'h2000, 16'hBEEF, 2'b11);
    @(negedge clk);
    chk("lat_idle_at_t", 32'(bus_a.busy), 32'h0);
    @(negedge clk);
    chk("lat_strobe_t1", 32'({bus_a.mem_read, bus_a.mem_addr}), {15'h0, 1'b1, 16'h1000});
    wait_resp_a(0);
    step();
    set_a(0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    wait_resp_a(1);
    step();
    set_a(1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);

    // Flush: ch1 drops its read and changes its fields while its access is in flight.
    lat_a = 3;
    q_a.push_back('{grant: 8'b10, rd: 1'b1, wr: 1'b0, addr: 16'h3000, wdata: 16'h1111,
                    be: 2'b01, rdata: 16'h5555});
    step();
    set_a(1, 1'b1, 1'b0, 16'h3000, 16'h1111, 2'b01);
    step();
    set_a(1, 1'b0, 1'b0, 16'h4000, 16'h9999, 2'b10);
    wait_resp_a(1);
    step();
    set_a(1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    lat_a = 1;

    // Read and write asserted together: the write wins.
    q_a.push_back('{grant: 8'b01, rd: 1'b0, wr: 1'b1, addr: 16'h0042, wdata: 16'hA5A5,
                    be: 2'b01, rdata: 16'h0000});
    step();
    set_a(0, 1'b1, 1'b1, 16'h0042, 16'hA5A5, 2'b01);
    wait_resp_a(0);
    step();
    set_a(0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);

    // Reset two cycles into a BUSY write abandons it, and a later mem_resp is ignored.
    resp_en_a = 1'b0;
    q_a.push_back('{grant: 8'b10, rd: 1'b0, wr: 1'b1, addr: 16'h2222, wdata: 16'h7777,
                    be: 2'b10, rdata: 16'h0000});
    step();
    set_a(1, 1'b0, 1'b1, 16'h2222, 16'h7777, 2'b10);
    step();
    step();
    reset = 1'b1;
    set_a(1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_busy", 32'(bus_a.busy), 32'h0);
    chk("rst_mid_grant", 32'(bus_a.grant), 32'h0);
    chk("rst_mid_strobes", 32'({bus_a.mem_read, bus_a.mem_write}), 32'h0);
    chk("rst_mid_addr", 32'(bus_a.mem_addr), 32'h0);
    chk("rst_mid_wdata_be", 32'({bus_a.mem_wdata, bus_a.mem_byte_enable}), 32'h0);
    chk("rst_mid_ch_resp", 32'(bus_a.ch_resp), 32'h0);
    q_a.delete(0);
    step();
    reset = 1'b0;
    step();
    manual_a = 1'b1;
    @(negedge clk);
    chk("idle_resp_busy", 32'(bus_a.busy), 32'h0);
    chk("idle_resp_ch_resp", 32'(bus_a.ch_resp), 32'h0);
    step();
    manual_a = 1'b0;
    @(negedge clk);
    chk("idle_resp_after", 32'(bus_a.busy), 32'h0);
    resp_en_a = 1'b1;

    // Back-to-back: ch0 holds its read. Strobes in cycles 1 and 4, and a turnaround in cycle 3.
    q_a.push_back('{grant: 8'b01, rd: 1'b1, wr: 1'b0, addr: 16'h0800, wdata: 16'h0000,
                    be: 2'b11, rdata: 16'hC0DE});
    q_a.push_back('{grant: 8'b01, rd: 1'b1, wr: 1'b0, addr: 16'h0800, wdata: 16'h0000,
                    be: 2'b11, rdata: 16'hF00D});
    step();
    set_a(0, 1'b1, 1'b0, 16'h0800, 16'h0000, 2'b11);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_strobe_c1", 32'(bus_a.mem_read), 32'h1);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_turnaround_c3", 32'(bus_a.busy), 32'h0);
    @(negedge clk);
    chk("b2b_strobe_c4", 32'(bus_a.mem_read), 32'h1);
    wait_resp_a(0);
    step();
    set_a(0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);

    // Round-robin over 3 channels that all request continuously.
    for (int i = 0; i < 6; i++) begin
      q_b.push_back('{grant: 8'(1 << (i % 3)), rd: 1'b1, wr: 1'b0,
                      addr: 16'(16'h0100 * ((i % 3) + 1)), wdata: 16'h0000, be: 2'b11,
                      rdata: 16'(16'h0B00 + i)});
    end
    step();
    for (int k = 0; k < 3; k++) set_b(k, 1'b1, 16'(16'h0100 * (k + 1)));
    for (int i = 0; i < 6; i++) wait_any_b();
    step();
    for (int k = 0; k < 3; k++) set_b(k, 1'b0, 16'h0);

    // Only ch2 requests after the wrap. Then all of them request, and ch0 must win.
    q_b.push_back('{grant: 8'b100, rd: 1'b1, wr: 1'b0, addr: 16'h0300, wdata: 16'h0000,
                    be: 2'b11, rdata: 16'h0C02});
    q_b.push_back('{grant: 8'b001, rd: 1'b1, wr: 1'b0, addr: 16'h0100, wdata: 16'h0000,
                    be: 2'b11, rdata: 16'h0C00});
    step();
    set_b(2, 1'b1, 16'h0300);
    wait_any_b();
    step();
    set_b(0, 1'b1, 16'h0100);
    set_b(1, 1'b1, 16'h0200);
    wait_any_b();
    step();
    for (int k = 0; k < 3; k++) set_b(k, 1'b0, 16'h0);

    repeat (4) @(negedge clk);
    chk("a_queue_drained", 32'(q_a.size()), 32'h0);
    chk("b_queue_drained", 32'(q_b.size()), 32'h0);
    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
